// File: rtl/smm_coo_to_csr.sv
// COO-to-CSR converter: buffers one descending row-major COO burst and replays it as
// ROWS+1 row pointers followed by ascending elements. Optional macro: SMM_CSR_ORDER_CHECK_EN.
module smm_coo_to_csr #(
  parameter int ROWS  = 32,
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [4:0] in_row,
  input  logic [4:0] in_col,
  input  logic [8:0] in_val,
  input  logic       in_done,
  output logic       busy,
  output logic       out_valid,
  output logic       out_kind,
  output logic [5:0] out_idx,
  output logic [6:0] out_ptr,
  output logic [4:0] out_col,
  output logic [8:0] out_val,
  output logic       out_last,
  output logic       err
);
  localparam logic [5:0] LAST_PTR = 6'(ROWS);
  localparam logic [6:0] FULL     = 7'(DEPTH);
  localparam int         AW       = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PTR, S_ELEM} state_t;
  state_t state_q, state_d;

  logic [6:0]  nnz_q, nnz_d;
  logic [6:0]  cnt_q [ROWS];
  logic [6:0]  cnt_d [ROWS];
  logic [5:0]  idx_q, idx_d;
  logic [6:0]  acc_q, acc_d;
  logic        err_q, err_d;
  logic [13:0] mem [DEPTH];

  logic          loading, row_ok, full, accept, order_err;
  logic          ptr_end, elem_end, frame_end;
  logic [6:0]    rd_ptr;
  logic [AW-1:0] rd_addr;

  logic       out_valid_q, out_valid_d, out_kind_q, out_kind_d;
  logic [5:0] out_idx_q, out_idx_d;
  logic [6:0] out_ptr_q, out_ptr_d;
  logic [4:0] out_col_q, out_col_d;
  logic [8:0] out_val_q, out_val_d;
  logic       out_last_q, out_last_d, busy_q, busy_d;

  assign loading   = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign row_ok    = {1'b0, in_row} < LAST_PTR;
  assign full      = (nnz_q == FULL);
  assign accept    = loading && in_valid && row_ok && !full;
  assign ptr_end   = (state_q == S_PTR) && (idx_q == LAST_PTR);
  assign elem_end  = (state_q == S_ELEM) && ({1'b0, idx_q} == nnz_q - 7'd1);
  assign frame_end = (ptr_end && (nnz_q == 7'd0)) || elem_end;
  // Stored in arrival (descending) order, so reading top-down yields ascending order.
  assign rd_ptr    = nnz_q - 7'd1 - {1'b0, idx_q};
  assign rd_addr   = rd_ptr[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (in_done)       state_d = S_PTR;
        else if (in_valid) state_d = S_LOAD;
      end
      S_PTR:   if (ptr_end)  state_d = (nnz_q != 7'd0) ? S_ELEM : S_IDLE;
      S_ELEM:  if (elem_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SMM_CSR_ORDER_CHECK_EN
  logic [9:0] prev_q, prev_d;
  logic       have_q, have_d;

  always_comb begin
    prev_d    = prev_q;
    have_d    = have_q;
    order_err = 1'b0;
    if (accept) begin
      order_err = have_q && !({in_row, in_col} < prev_q);
      prev_d    = {in_row, in_col};
      have_d    = 1'b1;
    end
    if (frame_end) have_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      have_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      have_q <= have_d;
    end
  end
`else
  assign order_err = 1'b0;
`endif

  always_comb begin
    nnz_d = nnz_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    acc_d = acc_q;
    err_d = err_q | order_err;
    if (accept) begin
      nnz_d         = nnz_q + 7'd1;
      cnt_d[in_row] = cnt_q[in_row] + 7'd1;
    end
    if (loading && in_valid && !accept)     err_d = 1'b1;
    if (!loading && (in_valid || in_done))  err_d = 1'b1;
    if (state_q == S_PTR) begin
      idx_d = ptr_end ? 6'd0 : idx_q + 6'd1;
      acc_d = ptr_end ? 7'd0 : acc_q + cnt_q[idx_q[4:0]];
    end else if (state_q == S_ELEM) begin
      idx_d = elem_end ? 6'd0 : idx_q + 6'd1;
    end
    if (frame_end) begin
      nnz_d = 7'd0;
      for (int r = 0; r < ROWS; r++) cnt_d[r] = 7'd0;
    end
  end

  always_comb begin
    out_valid_d = 1'b0;
    out_kind_d  = 1'b0;
    out_idx_d   = 6'd0;
    out_ptr_d   = 7'd0;
    out_col_d   = 5'd0;
    out_val_d   = 9'd0;
    out_last_d  = 1'b0;
    busy_d      = (state_d == S_PTR) || (state_d == S_ELEM);
    case (state_q)
      S_PTR: begin
        out_valid_d = 1'b1;
        out_idx_d   = idx_q;
        out_ptr_d   = acc_q;
        out_last_d  = ptr_end && (nnz_q == 7'd0);
      end
      S_ELEM: begin
        out_valid_d            = 1'b1;
        out_kind_d             = 1'b1;
        out_idx_d              = idx_q;
        {out_col_d, out_val_d} = mem[rd_addr];
        out_last_d             = elem_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[nnz_q[AW-1:0]] <= {in_col, in_val};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nnz_q       <= '0;
      for (int r = 0; r < ROWS; r++) cnt_q[r] <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_kind_q  <= 1'b0;
      out_idx_q   <= '0;
      out_ptr_q   <= '0;
      out_col_q   <= '0;
      out_val_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      nnz_q       <= nnz_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_kind_q  <= out_kind_d;
      out_idx_q   <= out_idx_d;
      out_ptr_q   <= out_ptr_d;
      out_col_q   <= out_col_d;
      out_val_q   <= out_val_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_kind  = out_kind_q;
  assign out_idx   = out_idx_q;
  assign out_ptr   = out_ptr_q;
  assign out_col   = out_col_q;
  assign out_val   = out_val_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
endmodule

// File: tb/tb_smm_coo_to_csr.sv
// Directed bench for smm_coo_to_csr: empty, basic, overflow, done-with-valid,
// mid-frame reset, back-to-back and key-order frames.
module tb_smm_coo_to_csr;
  localparam int ROWS = 32;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_done;
  logic [4:0] in_row, in_col;
  logic [8:0] in_val;
  logic       busy, out_valid, out_kind, out_last, err;
  logic [5:0] out_idx;
  logic [6:0] out_ptr;
  logic [4:0] out_col;
  logic [8:0] out_val;

  int checks = 0;
  int failures = 0;

  logic [6:0] got_ptr [ROWS+1];
  logic [4:0] got_col [64];
  logic [8:0] got_val [64];
  int         n_ptr, n_elem, lat, bad_seq;
  logic       last_kind;

  smm_coo_to_csr dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_row(in_row), .in_col(in_col),
    .in_val(in_val), .in_done(in_done), .busy(busy), .out_valid(out_valid),
    .out_kind(out_kind), .out_idx(out_idx), .out_ptr(out_ptr), .out_col(out_col),
    .out_val(out_val), .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [4:0] r, input logic [4:0] c, input logic [8:0] v,
                      input logic done);
    in_valid = 1'b1; in_row = r; in_col = c; in_val = v; in_done = done;
    tick();
    in_valid = 1'b0; in_done = 1'b0;
  endtask

  task automatic done_only();
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
  endtask

  // Call right after the cycle that presented in_done; collects beats until out_last.
  task automatic run_frame();
    n_ptr = 0; n_elem = 0; lat = 0; bad_seq = 0; last_kind = 1'b0;
    for (int i = 0; i <= ROWS; i++) got_ptr[i] = 7'h7f;
    for (int c = 1; c < 200; c++) begin
      tick();
      if (out_valid) begin
        if (!out_kind) begin
          if (n_elem != 0 || n_ptr > ROWS || int'(out_idx) != n_ptr ||
              out_col != 0 || out_val != 0) bad_seq++;
          if (n_ptr <= ROWS) got_ptr[n_ptr] = out_ptr;
          n_ptr++;
        end else begin
          if (n_ptr != ROWS + 1 || n_elem > 63 || int'(out_idx) != n_elem ||
              out_ptr != 0) bad_seq++;
          if (n_elem < 64) begin
            got_col[n_elem] = out_col;
            got_val[n_elem] = out_val;
          end
          n_elem++;
        end
        if (out_last) begin
          lat = c;
          last_kind = out_kind;
          break;
        end
      end else if (n_ptr != 0) bad_seq++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_done = 1'b0; in_row = '0; in_col = '0; in_val = '0;
    tick();
    checks++;
    if ({out_valid, out_kind, out_idx, out_ptr, out_col, out_val, out_last, busy, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0",
               {out_valid, out_kind, out_idx, out_ptr, out_col, out_val, out_last, busy, err});
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_empty();
    done_only();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL empty_busy: got %b expected 1", busy); end
    run_frame();
    checks++;
    if (n_ptr != 33 || n_elem != 0) begin
      failures++; $display("FAIL empty_beats: got ptr=%0d elem=%0d expected 33/0", n_ptr, n_elem);
    end
    begin
      int nz = 0;
      for (int i = 0; i <= ROWS; i++) if (got_ptr[i] !== 7'd0) nz++;
      checks++;
      if (nz != 0) begin failures++; $display("FAIL empty_ptr_zero: got %0d nonzero expected 0", nz); end
    end
    checks++;
    if (lat != 33) begin failures++; $display("FAIL empty_latency: got %0d expected 33", lat); end
    checks++;
    if (bad_seq != 0) begin failures++; $display("FAIL empty_seq: got %0d bad beats expected 0", bad_seq); end
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL empty_err_busy: got err=%b busy=%b expected 0/0", err, busy);
    end
  endtask

  task automatic test_basic();
    int bad = 0;
    send(5'd5, 5'd7, 9'd12, 1'b0);
    send(5'd2, 5'd3, 9'd40, 1'b0);
    send(5'd2, 5'd1, 9'd9, 1'b0);
    done_only();
    run_frame();
    for (int r = 0; r <= ROWS; r++)
      if (got_ptr[r] !== ((r <= 2) ? 7'd0 : (r <= 5) ? 7'd2 : 7'd3)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL basic_ptrs: got %0d wrong expected 0", bad); end
    checks++;
    if (got_ptr[3] !== 7'd2 || got_ptr[32] !== 7'd3) begin
      failures++; $display("FAIL basic_ptr3_32: got %0d/%0d expected 2/3", got_ptr[3], got_ptr[32]);
    end
    checks++;
    if (n_elem != 3) begin failures++; $display("FAIL basic_nelem: got %0d expected 3", n_elem); end
    checks++;
    if ({got_col[0], got_val[0]} !== {5'd1, 9'd9}) begin
      failures++; $display("FAIL basic_e0: got col=%0d val=%0d expected 1/9", got_col[0], got_val[0]);
    end
    checks++;
    if ({got_col[1], got_val[1]} !== {5'd3, 9'd40}) begin
      failures++; $display("FAIL basic_e1: got col=%0d val=%0d expected 3/40", got_col[1], got_val[1]);
    end
    checks++;
    if ({got_col[2], got_val[2]} !== {5'd7, 9'd12}) begin
      failures++; $display("FAIL basic_e2: got col=%0d val=%0d expected 7/12", got_col[2], got_val[2]);
    end
    checks++;
    if (lat != 36 || last_kind !== 1'b1) begin
      failures++; $display("FAIL basic_last: got lat=%0d kind=%b expected 36/1", lat, last_kind);
    end
    checks++;
    if (bad_seq != 0 || err !== 1'b0) begin
      failures++; $display("FAIL basic_seq_err: got bad=%0d err=%b expected 0/0", bad_seq, err);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] key;
    int bad = 0;
    for (int i = 0; i <= 64; i++) begin
      key = 10'(1023 - i);
      send(key[9:5], key[4:0], 9'(i), 1'b0);
    end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL ovf_err: got %b expected 1", err); end
    done_only();
    run_frame();
    checks++;
    if (got_ptr[31] !== 7'd32 || got_ptr[32] !== 7'd64) begin
      failures++; $display("FAIL ovf_ptr: got %0d/%0d expected 32/64", got_ptr[31], got_ptr[32]);
    end
    checks++;
    if (n_elem != 64 || lat != 97) begin
      failures++; $display("FAIL ovf_count: got elem=%0d lat=%0d expected 64/97", n_elem, lat);
    end
    for (int j = 0; j < 64; j++)
      if (got_col[j] !== 5'(j) || got_val[j] !== 9'(63 - j)) bad++;
    checks++;
    if (bad != 0 || bad_seq != 0) begin
      failures++; $display("FAIL ovf_elems: got %0d wrong, %0d bad beats expected 0/0", bad, bad_seq);
    end
    do_reset();
  endtask

  task automatic test_valid_with_done();
    send(5'd0, 5'd0, 9'd1, 1'b1);
    run_frame();
    checks++;
    if (got_ptr[0] !== 7'd0 || got_ptr[1] !== 7'd1 || got_ptr[32] !== 7'd1) begin
      failures++; $display("FAIL vwd_ptr: got %0d/%0d/%0d expected 0/1/1",
                           got_ptr[0], got_ptr[1], got_ptr[32]);
    end
    checks++;
    if (n_elem != 1 || {got_col[0], got_val[0]} !== {5'd0, 9'd1} || last_kind !== 1'b1 || lat != 34) begin
      failures++; $display("FAIL vwd_elem: got n=%0d col=%0d val=%0d kind=%b lat=%0d expected 1/0/1/1/34",
                           n_elem, got_col[0], got_val[0], last_kind, lat);
    end
  endtask

  task automatic test_reset_mid();
    send(5'd3, 5'd3, 9'd3, 1'b1);
    tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_kind !== 1'b0) begin
      failures++; $display("FAIL mid_in_ptr: got valid=%b kind=%b expected 1/0", out_valid, out_kind);
    end
    send(5'd1, 5'd1, 9'd1, 1'b0);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL busy_input_err: got %b expected 1", err); end
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_kind, out_idx, out_ptr, out_col, out_val, out_last, busy, err} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %h expected 0",
               {out_valid, out_kind, out_idx, out_ptr, out_col, out_val, out_last, busy, err});
    end
    rst = 1'b0;
    send(5'd31, 5'd31, 9'd511, 1'b0);
    done_only();
    run_frame();
    checks++;
    if (got_ptr[31] !== 7'd0 || got_ptr[32] !== 7'd1 || got_ptr[4] !== 7'd0) begin
      failures++; $display("FAIL mid_next_ptr: got %0d/%0d/%0d expected 0/1/0",
                           got_ptr[4], got_ptr[31], got_ptr[32]);
    end
    checks++;
    if (n_elem != 1 || {got_col[0], got_val[0]} !== {5'd31, 9'd511} || err !== 1'b0) begin
      failures++; $display("FAIL mid_next_elem: got n=%0d col=%0d val=%0d err=%b expected 1/31/511/0",
                           n_elem, got_col[0], got_val[0], err);
    end
  endtask

  task automatic test_back_to_back();
    send(5'd1, 5'd1, 9'd1, 1'b1);
    run_frame();
    send(5'd2, 5'd2, 9'd2, 1'b1);
    run_frame();
    checks++;
    if (got_ptr[2] !== 7'd0 || got_ptr[3] !== 7'd1 || got_ptr[32] !== 7'd1) begin
      failures++; $display("FAIL b2b_ptr: got %0d/%0d/%0d expected 0/1/1",
                           got_ptr[2], got_ptr[3], got_ptr[32]);
    end
    checks++;
    if (n_elem != 1 || {got_col[0], got_val[0]} !== {5'd2, 9'd2} || err !== 1'b0 || bad_seq != 0) begin
      failures++; $display("FAIL b2b_elem: got n=%0d col=%0d val=%0d err=%b bad=%0d expected 1/2/2/0/0",
                           n_elem, got_col[0], got_val[0], err, bad_seq);
    end
  endtask

  task automatic test_order();
    logic exp_err;
`ifdef SMM_CSR_ORDER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    send(5'd1, 5'd2, 9'd5, 1'b0);
    send(5'd3, 5'd0, 9'd6, 1'b0);
    done_only();
    run_frame();
    checks++;
    if (err !== exp_err) begin failures++; $display("FAIL order_err: got %b expected %b", err, exp_err); end
    checks++;
    if (n_elem != 2 || got_ptr[2] !== 7'd1 || got_ptr[4] !== 7'd2 ||
        {got_col[0], got_val[0]} !== {5'd0, 9'd6}) begin
      failures++; $display("FAIL order_stored: got n=%0d p2=%0d p4=%0d col=%0d val=%0d expected 2/1/2/0/6",
                           n_elem, got_ptr[2], got_ptr[4], got_col[0], got_val[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_empty();
    test_basic();
    test_overflow();
    test_valid_with_done();
    test_reset_mid();
    test_back_to_back();
    test_order();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/smm_coo_to_csr.md
# smm_coo_to_csr

Downstream stage of the sparse matrix multiplier. It captures the multiplier's COO result burst, which arrives as (row, col, val) triples in strictly descending row-major order. It then re-emits the result in CSR form: first ROWS+1 row-pointer beats, then all nonzero elements in ascending row-major order. It buffers one complete result matrix and flags malformed or oversized bursts.

## Interface
- ROWS, 32, number of matrix rows; row indices are 5 bits, so ROWS ≤ 32
- DEPTH, 64, element buffer capacity; pointer width is 7 bits
- clk  input  1  clock; all logic is on the rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  element beat from the multiplier
- in_row  input  5  element row
- in_col  input  5  element column
- in_val  input  9  element value; 0 is legal and is stored
- in_done  input  1  one-cycle end-of-frame pulse; may coincide with the last in_valid
- busy  output  1  high in states PTR and ELEM
- out_valid  output  1  output beat
- out_kind  output  1  0 = row pointer, 1 = element
- out_idx  output  6  pointer index 0..ROWS, or element index 0..nnz-1
- out_ptr  output  7  row pointer value; 0 on element beats
- out_col  output  5  element column; 0 on pointer beats
- out_val  output  9  element value; 0 on pointer beats
- out_last  output  1  high on the final beat of a frame
- err  output  1  sticky error flag; cleared only by rst

## Operation
- States: IDLE, LOAD, PTR, ELEM.
- **IDLE**
  - nnz counter and all ROWS row counters are zero.
  - in_valid writes the triple to buf[0], increments the counter for in_row, and moves to LOAD.
  - in_done moves to PTR; an empty frame is legal.
- **LOAD**
  - Each in_valid writes buf[nnz] and increments nnz and cnt[in_row].
  - in_done moves to PTR. If in_valid is also high that cycle, the element is accepted first.
- **PTR**
  - Emits ROWS+1 beats, one per cycle: ptr[0]=0 and ptr[r+1]=ptr[r]+cnt[r], computed by a running adder.
  - After index ROWS, goes to ELEM if nnz>0, otherwise to IDLE.
- **ELEM**
  - Reads the buffer LIFO, from buf[nnz-1] down to buf[0], so output is ascending row-major.
  - out_idx counts 0..nnz-1.
  - After the last element, goes to IDLE and clears all counters.
- out_last:
  - Set on the element with out_idx = nnz-1.
  - Set on the pointer beat with out_idx = ROWS when nnz = 0.
- Overflow: an in_valid received when nnz = DEPTH is dropped, with no counter update, and sets err.
- in_valid or in_done during PTR or ELEM is ignored and sets err.
- in_row ≥ ROWS: the element is dropped and err is set.
- Widths:
  - cnt[r] is 7 bits.
  - The pointer sum saturates at DEPTH by construction; no wrap is possible.

## Timing
- Reset values:
  - out_valid, out_kind, out_idx, out_ptr, out_col, out_val, out_last, busy and err are all 0.
  - State is IDLE and all counters are 0.
- rst asserted mid-frame or mid-output abandons the frame. From the next cycle, the block behaves exactly as at power-up.
- All outputs are registered.
- If in_done is sampled at edge t, the first pointer beat is visible after edge t+1.
- Pointer beats are back-to-back, and the first element beat directly follows ptr[ROWS].
- Frame latency from in_done to out_last is ROWS+1+nnz cycles.
- There is no backpressure; the consumer must accept every beat.
- A new frame may start on the cycle after out_last, when the state is IDLE.

## Configuration
- Macro: SMM_CSR_ORDER_CHECK_EN.
- When defined:
  - LOAD compares each accepted {in_row,in_col} against the previous accepted key.
  - A key that is not strictly less than the previous one sets err.
  - The element is still stored.
- When undefined:
  - The comparator and the previous-key register are not built.
  - Order violations go undetected; err still reports overflow, bad row and busy-time input.

## Test plan
- Empty frame: in_done alone in IDLE -> 33 pointer beats, all with out_ptr=0; out_last on out_idx=32; err=0.
- Frame of (5,7,12), (2,3,40), (2,1,9), then in_done:
  - ptr[0..2]=0, ptr[3..5]=2, ptr[6..32]=3.
  - Elements in order: (col1,9), (col3,40), (col7,12); out_last on the third element.
- Overflow with DEPTH=64: send 65 descending elements -> err=1; ptr[32]=64; 64 element beats are emitted; the 65th triple never appears.
- in_valid together with in_done on the last element (0,0,1) -> the element is included; the single element beat has out_last=1.
- rst pulsed during PTR -> all outputs 0 on the next cycle. The next frame, (31,31,511) then in_done, gives ptr[32]=1 and a single element beat (col31, val511).
- With SMM_CSR_ORDER_CHECK_EN: send (1,2) followed by (3,0) -> err=1. Without the macro, the same stimulus leaves err=0.
